// File: rtl/fp_class_pipe.sv
// Two-stage floating-point classifier: decodes each lane into a one-hot class word
// and keeps saturating per-class statistics of delivered results.
module fp_class_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int LANES = 1,
    parameter int CNT_W = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANES*(1+EXP_W+MAN_W)-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES*32-1:0]              out_class,
    input  logic [3:0]                       stat_sel,
    input  logic                             stat_clr,
    output logic [CNT_W-1:0]                 stat_count
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int NCLS = 10;

    logic                 s1_valid;
    logic                 s2_valid;
    logic [LANES-1:0]     s1_sign;
    logic [LANES-1:0]     s1_exp_one;
    logic [LANES-1:0]     s1_exp_zero;
    logic [LANES-1:0]     s1_man_zero;
    logic [LANES-1:0]     s1_man_msb;
    logic [LANES*32-1:0]  s2_class;

    logic [LANES-1:0]     d_sign;
    logic [LANES-1:0]     d_exp_one;
    logic [LANES-1:0]     d_exp_zero;
    logic [LANES-1:0]     d_man_zero;
    logic [LANES-1:0]     d_man_msb;
    logic [W-1:0]         lane;
    logic [LANES*32-1:0]  class_next;

    logic                 s1_open;
    logic                 s2_open;
    logic                 in_fire;
    logic                 out_fire;

    logic [CNT_W-1:0]     cnt      [NCLS];
    logic [CNT_W-1:0]     cnt_next [NCLS];
    logic [3:0]           inc      [NCLS];
    logic [CNT_W+3:0]     sum;

    function automatic logic [9:0] classify(input logic sign, input logic exp_one,
                                            input logic exp_zero, input logic man_zero,
                                            input logic man_msb);
        logic [9:0] c;
        c = '0;
        if (exp_one) begin
            if (!man_zero) begin
                if (man_msb) c[9] = 1'b1;
                else         c[8] = 1'b1;
            end else if (sign) c[0] = 1'b1;
            else               c[7] = 1'b1;
        end else if (exp_zero) begin
            if (man_zero) begin
                if (sign) c[3] = 1'b1;
                else      c[4] = 1'b1;
            end else if (sign) c[2] = 1'b1;
            else               c[5] = 1'b1;
        end else if (sign) c[1] = 1'b1;
        else               c[6] = 1'b1;
        return c;
    endfunction

    // A stage may load when it is empty or the stage after it moves on this cycle.
    assign s2_open   = ~s2_valid | out_ready;
    assign s1_open   = ~s1_valid | s2_open;
    assign in_ready  = ~rst & s1_open;
    assign out_valid = ~rst & s2_valid;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_class = s2_class;

    always_comb begin
        lane       = '0;
        d_sign     = '0;
        d_exp_one  = '0;
        d_exp_zero = '0;
        d_man_zero = '0;
        d_man_msb  = '0;
        for (int k = 0; k < LANES; k++) begin
            lane          = in_data[k*W +: W];
            d_sign[k]     = lane[W-1];
            d_exp_one[k]  = &lane[MAN_W +: EXP_W];
            d_exp_zero[k] = ~|lane[MAN_W +: EXP_W];
            d_man_zero[k] = ~|lane[MAN_W-1:0];
            d_man_msb[k]  = lane[MAN_W-1];
        end
    end

    always_comb begin
        class_next = '0;
        for (int k = 0; k < LANES; k++) begin
            class_next[k*32 +: 32] = {22'b0, classify(s1_sign[k], s1_exp_one[k],
                                      s1_exp_zero[k], s1_man_zero[k], s1_man_msb[k])};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            s1_sign     <= '0;
            s1_exp_one  <= '0;
            s1_exp_zero <= '0;
            s1_man_zero <= '0;
            s1_man_msb  <= '0;
            s2_class    <= '0;
        end else begin
            if (s1_open) begin
                s1_valid <= in_fire;
                if (in_fire) begin
                    s1_sign     <= d_sign;
                    s1_exp_one  <= d_exp_one;
                    s1_exp_zero <= d_exp_zero;
                    s1_man_zero <= d_man_zero;
                    s1_man_msb  <= d_man_msb;
                end
            end
            if (s2_open) begin
                s2_valid <= s1_valid;
                if (s1_valid) s2_class <= class_next;
            end
        end
    end

    // Any carry into the top four bits of the widened sum means the counter saturates.
    always_comb begin
        sum = '0;
        for (int b = 0; b < NCLS; b++) begin
            inc[b] = '0;
            for (int k = 0; k < LANES; k++) begin
                inc[b] = inc[b] + 4'(s2_class[32*k + b]);
            end
            sum         = {4'b0, cnt[b]} + {{CNT_W{1'b0}}, inc[b]};
            cnt_next[b] = (sum[CNT_W+3:CNT_W] != 4'b0) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NCLS; b++) begin
            if (rst || stat_clr) cnt[b] <= '0;
            else if (out_fire)   cnt[b] <= cnt_next[b];
        end
    end

    always_comb begin
        stat_count = '0;
        for (int b = 0; b < NCLS; b++) begin
            if (stat_sel == 4'(b)) stat_count = cnt[b];
        end
    end

endmodule

// File: doc/fp_class_pipe.md
FP_CLASS_PIPE -- requirements
Module: fp_class_pipe

Interface
- REQ-001 SHALL have parameter EXP_W, default 8: exponent field width.
- REQ-002 SHALL have parameter MAN_W, default 23: mantissa field width, must be >= 2.
- REQ-003 SHALL have parameter LANES, default 1: operands classified per transfer, range 1..8.
- REQ-004 SHALL have parameter CNT_W, default 16: width of each statistics counter.
- REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-007 SHALL have port in_valid, input, 1 bit: in_data holds a valid operand group.
- REQ-008 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
- REQ-009 SHALL have port in_data, input, LANES*(1+EXP_W+MAN_W) bits: lane k occupies slice k; lane 0 is least significant.
- REQ-010 SHALL have port out_valid, output, 1 bit: out_class holds a valid result group.
- REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts out_class this cycle.
- REQ-012 SHALL have port out_class, output, LANES*32 bits: per-lane class word; lane k is bits [32k+31:32k].
- REQ-013 SHALL have port stat_sel, input, 4 bits: selects the class counter to read.
- REQ-014 SHALL have port stat_clr, input, 1 bit: clears all class counters.
- REQ-015 SHALL have port stat_count, output, CNT_W bits: value of the selected counter.

Function
- REQ-016 SHALL split each lane as follows: sign = MSB; exponent = next EXP_W bits; mantissa = low MAN_W bits.
- REQ-017 SHALL set exactly one of bits [9:0] in each lane's class word, with bits [31:10] = 0, using this encoding: bit0 -inf, bit1 -normal, bit2 -subnormal, bit3 -zero, bit4 +zero, bit5 +subnormal, bit6 +normal, bit7 +inf, bit8 sNaN, bit9 qNaN.
- REQ-018 SHALL apply these class rules: exponent all ones with mantissa zero is inf; exponent all ones with mantissa nonzero is NaN; that NaN is qNaN if mantissa MSB = 1, else sNaN; a NaN is never classified by sign.
- REQ-019 SHALL continue the class rules: exponent zero with mantissa zero is zero; exponent zero with mantissa nonzero is subnormal; any other exponent is normal.
- REQ-020 SHALL be a two-stage pipeline: stage 1 registers per-lane sign and the expAllOne, expAllZero, manZero and manMsb flags; stage 2 registers the class words.
- REQ-021 SHALL present the result on out_class/out_valid exactly 2 cycles after input acceptance when out_ready is held high.
- REQ-022 SHALL accept an input only when in_valid and in_ready are both high, and SHALL deliver an output only when out_valid and out_ready are both high.
- REQ-023 SHALL sustain one transfer per cycle when out_ready is continuously high.
- REQ-024 SHALL let a stage advance when its successor is empty or is draining this cycle: in_ready = ~s1_valid | ~s2_valid | out_ready, combinational from registered state and out_ready.
- REQ-025 SHALL, during backpressure (out_valid=1, out_ready=0), hold out_class stable and hold up to 2 groups (s1, s2) without loss or duplication.
- REQ-026 SHALL not let out_valid depend combinationally on in_valid.
- REQ-027 SHALL keep 10 counters, one per class bit; on each output transfer each counter adds the number of lanes (0..LANES) carrying its class.
- REQ-028 SHALL saturate every counter at 2^CNT_W-1, with no wrap.
- REQ-029 SHALL make a counter zero on the next cycle when stat_clr=1, even if an output transfer occurs in the same cycle (that cycle's increments are discarded).
- REQ-030 SHALL drive stat_count from the registered counter selected by stat_sel 0..9, and SHALL drive 0 for stat_sel 10..15.
- REQ-031 SHALL not let stat_clr affect pipeline contents or the handshake.

Reset
- REQ-032 SHALL, with rst=1 at a clock edge, clear s1_valid, s2_valid, all stage registers, out_class and all counters to 0.
- REQ-033 SHALL drive in_ready=0 and out_valid=0 while rst=1, and in_ready=1 in the first cycle after rst deasserts.
- REQ-034 SHALL, when reset is asserted mid-stream, discard in-flight groups without counting them, and no output transfer SHALL occur in the cycle rst=1.

Verification
- REQ-035 SHALL test defaults with a stream 0x7F800000, 0xFF800001, 0x7FC00000, 0x00000001, 0x80000000 and out_ready=1, which must give out_class 0x80, 0x100, 0x200, 0x20, 0x08 on consecutive cycles, with the first result 2 cycles after the first acceptance.
- REQ-036 SHALL test backpressure: stream 8 operands with out_ready=0 for cycles 3..7, which must give in_ready=0 once 2 groups are held, all 8 results in order, and none lost or repeated.
- REQ-037 SHALL test EXP_W=5, MAN_W=10, LANES=2 with in_data {0x7C00, 0x0200}, which must give out_class lane0 0x20 (+subnormal) and lane1 0x80 (+inf).
- REQ-038 SHALL test CNT_W=4 with 20 transfers of +zero and then stat_sel=4, which must give stat_count=15; stat_clr coincident with a transfer must then give stat_count=0; stat_sel=12 must give 0.
- REQ-039 SHALL test reset mid-stream: rst=1 for 1 cycle with 2 groups in flight must give out_valid=0 afterwards, all counters 0, and in_ready=1 on the next cycle.
